// File: rtl/cpu4_ifetch.sv
// Instruction fetch: one outstanding imem read at a time, buffering {pc, word} pairs for the datapath.
// Latency: imem_ack in cycle n shows up as instr_valid in cycle n+1 when the buffer was empty.
// Backpressure: instr_ready low stalls the buffer; new requests issue only while count + outstanding <= FIFO_DEPTH.
module cpu4_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_nxt;
    logic [31:0]   pend_pc, pend_nxt;
    logic [31:0]   target;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   word_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop;

    assign target      = {redirect_pc[31:2], 2'b00};
    assign imem_req    = (state != IDLE);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? word_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    // During DROP the outstanding address stays on imem_addr; the redirect target waits in pend_pc.
    always_comb begin
        push      = (state == REQ) && imem_ack && !redirect;
        pop       = instr_valid && instr_ready && !redirect;
        count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
        state_nxt = state;
        fetch_nxt = fetch_pc;
        pend_nxt  = pend_pc;
        case (state)
            IDLE: begin
                if (redirect)
                    fetch_nxt = target;
                else if (count_nxt < DEPTH)
                    state_nxt = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        state_nxt = IDLE;
                        fetch_nxt = target;
                    end else begin
                        state_nxt = DROP;
                        pend_nxt  = target;
                    end
                end else if (imem_ack) begin
                    fetch_nxt = fetch_pc + 32'd4;
                    state_nxt = (count_nxt < DEPTH) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                    fetch_nxt = redirect ? target : pend_pc;
                end else if (redirect) begin
                    pend_nxt = target;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_nxt;
            pend_pc  <= pend_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
        end
    end

    // Storage needs no reset: the head is masked by instr_valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            word_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_cpu4_ifetch.sv
// Directed bench for cpu4_ifetch: streaming, backpressure, redirects, address wrap and reset mid-request.
module tb_cpu4_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    cpu4_ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_req",   {31'h0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            RST_PC);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr,                32'h0);
        check("rst_ipc",   instr_pc,             32'h0);

        // Streaming: ack every request, always ready.
        instr_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("strm_req",  {31'h0, imem_req}, 32'h1);
            check("strm_addr", imem_addr, RST_PC + 32'(4 * k));
            if (k > 0) begin
                check("strm_ipc",   instr_pc, RST_PC + 32'(4 * (k - 1)));
                check("strm_instr", instr,    word_of(RST_PC + 32'(4 * (k - 1))));
            end
            imem_ack = 1'b1;
            imem_rdata = word_of(RST_PC + 32'(4 * k));
            tick();
        end

        // Backpressure: buffer fills with two words, requests stop.
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        check("bp_req0",  {31'h0, imem_req}, 32'h1);
        check("bp_addr0", imem_addr, RST_PC);
        imem_rdata = word_of(RST_PC);
        tick();
        check("bp_addr1", imem_addr, RST_PC + 32'h4);
        check("bp_ipc0",  instr_pc,  RST_PC);
        imem_rdata = word_of(RST_PC + 32'h4);
        tick();
        check("bp_full_req", {31'h0, imem_req}, 32'h0);
        check("bp_full_addr", imem_addr, RST_PC + 32'h8);
        check("bp_full_ipc", instr_pc, RST_PC);
        check("bp_full_ins", instr, word_of(RST_PC));
        imem_ack = 1'b0;
        tick();
        check("bp_hold_req", {31'h0, imem_req}, 32'h0);
        check("bp_hold_ipc", instr_pc, RST_PC);
        instr_ready = 1'b1;
        tick();
        check("bp_res_req",  {31'h0, imem_req}, 32'h1);
        check("bp_res_addr", imem_addr, RST_PC + 32'h8);
        check("bp_res_ipc",  instr_pc,  RST_PC + 32'h4);
        instr_ready = 1'b0;

        // Redirect while the request to +8 is pending.
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("drop_req",   {31'h0, imem_req}, 32'h1);
        check("drop_addr",  imem_addr, RST_PC + 32'h8);
        check("drop_valid", {31'h0, instr_valid}, 32'h0);
        check("drop_ipc",   instr_pc, 32'h0);
        tick();
        check("drop_hold", imem_addr, RST_PC + 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("drop_idle_req", {31'h0, imem_req}, 32'h0);
        check("drop_idle_addr", imem_addr, 32'h0000_0100);
        check("drop_discard", {31'h0, instr_valid}, 32'h0);
        tick();
        check("rd_req",  {31'h0, imem_req}, 32'h1);
        check("rd_addr", imem_addr, 32'h0000_0100);

        // Redirect coincident with ack, unaligned target.
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        check("rda_valid", {31'h0, instr_valid}, 32'h0);
        check("rda_req",   {31'h0, imem_req}, 32'h0);
        check("rda_addr",  imem_addr, 32'h0000_0200);
        tick();
        check("rda_next", imem_addr, 32'h0000_0200);

        // Wrap at the top of the address space.
        imem_ack = 1'b1; imem_rdata = 32'h0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        tick();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = word_of(32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_ipc0",  instr_pc,  32'hFFFF_FFFC);
        check("wrap_ins0",  instr,     word_of(32'hFFFF_FFFC));
        imem_rdata = word_of(32'h0);
        tick();
        check("wrap_ipc1", instr_pc,  32'h0000_0000);
        check("wrap_ins1", instr,     word_of(32'h0));
        check("wrap_addr2", imem_addr, 32'h0000_0004);

        // Reset while a request is outstanding, then a late ack.
        imem_ack = 1'b0; instr_ready = 1'b0;
        check("mid_req_pre", {31'h0, imem_req}, 32'h1);
        reset = 1'b1;
        tick();
        check("mid_req",   {31'h0, imem_req}, 32'h0);
        check("mid_valid", {31'h0, instr_valid}, 32'h0);
        check("mid_addr",  imem_addr, RST_PC);
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFEED_FACE;
        tick();
        imem_ack = 1'b0;
        check("late_valid", {31'h0, instr_valid}, 32'h0);
        check("late_req",   {31'h0, imem_req}, 32'h1);
        check("late_addr",  imem_addr, RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
